// File: rtl/conv_window_sequencer_pkg.sv
// Shared accelerator definitions for the convolution window sequencer.
// Holds the sequencer state encoding and the default window capacity.
package conv_window_sequencer_pkg;

    localparam int CWS_CELL_NUMS = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DIVIDE   = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_WAIT_PAR = 3'd4,
        ST_EMIT     = 3'd5,
        ST_FINISH   = 3'd6
    } cws_state_e;

    function automatic logic [3:0] sat_win(
        input logic [3:0] n,
        input logic [3:0] cap
    );
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/conv_window_sequencer_div.sv
// Repeated-subtraction window counter: one subtraction per cycle.
// quot_p1 = floor(dividend / divisor) + 1, valid while done is high.
module window_count_div #(
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    dividend,
    input  logic [SW-1:0] divisor,
    output logic          done,
    output logic [3:0]    quot_p1
);

    localparam int CW = (SW > 4) ? SW : 4;

    logic          run_q, run_d;
    logic [3:0]    rem_q, rem_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] div_w;
    logic          ge;

    always_comb begin
        rem_w = CW'(rem_q);
        div_w = CW'(divisor);
        ge    = (rem_w >= div_w);
        done  = run_q && !ge;
        run_d = run_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        if (start) begin
            run_d = 1'b1;
            rem_d = dividend;
            cnt_d = 4'd1;
        end else if (run_q) begin
            if (ge) begin
                rem_d = rem_q - div_w[3:0];
                cnt_d = cnt_q + 4'd1;
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            rem_q <= 4'd0;
            cnt_q <= 4'd0;
        end else begin
            run_q <= run_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign quot_p1 = cnt_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences one row of convolution windows: validates the config, counts
// windows, then launches the checker and hands each partial sum downstream.
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int STRIDE_SIZE = 2,
    parameter int CELL_NUMS   = CWS_CELL_NUMS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STRIDE_SIZE:0] stride,
    input  logic [2:0]           filter_size,
    input  logic [2:0]           if_size,
    input  logic                 par_done,
    input  logic                 chk_done,
    input  logic                 psum_ready,
    output logic                 inner_start,
    output logic                 psum_valid,
    output logic [2:0]           window_idx,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 all_done
);

    cws_state_e state_q, state_d;

    logic [STRIDE_SIZE:0] stride_q, stride_d;
    logic [2:0]           fsize_q, fsize_d;
    logic [2:0]           ifsize_q, ifsize_d;
    logic [3:0]           num_win_q, num_win_d;
    logic [2:0]           win_idx_q, win_idx_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 div_start;
    logic                 div_done;
    logic [3:0]           div_cnt;
    logic [3:0]           rem_init;

    assign rem_init = {1'b0, ifsize_q} - {1'b0, fsize_q};

    window_count_div #(
        .SW (STRIDE_SIZE + 1)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (rem_init),
        .divisor  (stride_q),
        .done     (div_done),
        .quot_p1  (div_cnt)
    );

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        fsize_d     = fsize_q;
        ifsize_d    = ifsize_q;
        num_win_d   = num_win_q;
        win_idx_d   = win_idx_q;
        cfg_err_d   = cfg_err_q;
        div_start   = 1'b0;
        inner_start = 1'b0;
        psum_valid  = 1'b0;
        all_done    = 1'b0;
        busy        = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stride_d  = stride;
                    fsize_d   = filter_size;
                    ifsize_d  = if_size;
                    cfg_err_d = 1'b0;
                    win_idx_d = 3'd0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (stride_q == '0 || fsize_q == 3'd0 ||
                    fsize_q > ifsize_q) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    num_win_d = sat_win(div_cnt, 4'(CELL_NUMS));
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                inner_start = 1'b1;
                state_d     = ST_WAIT_PAR;
            end
            ST_WAIT_PAR: begin
                // A global abort outranks a partial sum arriving alongside it
                if (chk_done) begin
                    state_d = ST_FINISH;
                end else if (par_done) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                psum_valid = 1'b1;
                if (psum_ready) begin
                    if ({1'b0, win_idx_q} == num_win_q - 4'd1) begin
                        state_d = ST_FINISH;
                    end else begin
                        win_idx_d = win_idx_q + 3'd1;
                        state_d   = ST_LAUNCH;
                    end
                end
            end
            ST_FINISH: begin
                all_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stride_q  <= '0;
            fsize_q   <= 3'd0;
            ifsize_q  <= 3'd0;
            num_win_q <= 4'd0;
            win_idx_q <= 3'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            fsize_q   <= fsize_d;
            ifsize_q  <= ifsize_d;
            num_win_q <= num_win_d;
            win_idx_q <= win_idx_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign window_idx = win_idx_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized self-checking bench for conv_window_sequencer against a
// row-level arithmetic model of window count and launch latency.
module tb_conv_window_sequencer;

    localparam int CELLS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] stride = 3'd0;
    logic [2:0] filter_size = 3'd0;
    logic [2:0] if_size = 3'd0;
    logic       par_done = 1'b0;
    logic       chk_done = 1'b0;
    logic       psum_ready = 1'b0;
    logic       inner_start;
    logic       psum_valid;
    logic [2:0] window_idx;
    logic       busy;
    logic       cfg_err;
    logic       all_done;

    int tests_run = 0;
    int failed = 0;

    typedef struct {
        int n_launch;
        int n_emit;
        int n_done;
        int emit_cycles;
        int lat;
        int bad;
        int busy_after;
        int err;
        int err_after;
        int timeout;
    } row_obs_t;

    always #5 clk = ~clk;

    conv_window_sequencer #(
        .STRIDE_SIZE (2),
        .CELL_NUMS   (CELLS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stride      (stride),
        .filter_size (filter_size),
        .if_size     (if_size),
        .par_done    (par_done),
        .chk_done    (chk_done),
        .psum_ready  (psum_ready),
        .inner_start (inner_start),
        .psum_valid  (psum_valid),
        .window_idx  (window_idx),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .all_done    (all_done)
    );

    function automatic int model_nwin(input int ifs, input int fs, input int st);
        int raw;
        if (st == 0 || fs == 0 || fs > ifs) return 0;
        raw = (ifs - fs) / st + 1;
        return (raw > CELLS) ? CELLS : raw;
    endfunction

    function automatic int model_err(input int ifs, input int fs, input int st);
        return (st == 0 || fs == 0 || fs > ifs) ? 1 : 0;
    endfunction

    function automatic int model_lat(input int ifs, input int fs, input int st);
        if (model_err(ifs, fs, st) != 0) return -1;
        return 3 + (ifs - fs) / st;
    endfunction

    // Drives one row starting in the current cycle (caller sits at a negedge)
    // and records what the DUT did; returns at the negedge of the cycle after all_done.
    task automatic run_row(input int ifs, input int fs, input int st,
                           input int pd, input int stall, input int abort_win,
                           output row_obs_t o);
        int cyc;
        int par_at;
        int stall_left;
        o = '{default: 0};
        o.lat = -1;
        par_at = -1;
        stall_left = stall;
        start = 1'b1;
        if_size = 3'(ifs);
        filter_size = 3'(fs);
        stride = 3'(st);
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 400; cyc++) begin
            if_size = 3'($urandom);
            filter_size = 3'($urandom);
            stride = 3'($urandom);
            start = 1'($urandom);
            if (!busy) o.bad++;
            if (inner_start && psum_valid) o.bad++;
            if (inner_start) begin
                o.n_launch++;
                if (o.lat < 0) o.lat = cyc;
                par_at = cyc + pd;
            end
            par_done = (cyc == par_at);
            chk_done = par_done && (o.n_launch - 1 == abort_win);
            if (psum_valid) begin
                o.emit_cycles++;
                if (window_idx !== 3'(o.n_emit)) o.bad++;
                if (stall_left > 0) begin
                    psum_ready = 1'b0;
                    stall_left--;
                end else begin
                    psum_ready = 1'b1;
                    o.n_emit++;
                    stall_left = stall;
                end
            end else begin
                psum_ready = 1'($urandom);
            end
            if (all_done) begin
                o.n_done++;
                o.err = int'(cfg_err);
                start = 1'b0;
                par_done = 1'b0;
                chk_done = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (cyc >= 400) o.timeout = 1;
        start = 1'b0;
        par_done = 1'b0;
        chk_done = 1'b0;
        psum_ready = 1'b0;
        @(negedge clk);
        o.busy_after = int'(busy);
        o.err_after = int'(cfg_err);
        if (all_done) o.n_done++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({inner_start, psum_valid, busy, cfg_err, all_done} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags got %b want 00000",
                     {inner_start, psum_valid, busy, cfg_err, all_done});
        end
        tests_run++;
        if (window_idx !== 3'd0) begin
            failed++;
            $display("FAIL reset_idx got %0d want 0", window_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        row_obs_t o;
        run_row(7, 3, 2, 2, 0, -1, o);
        tests_run++;
        if (o.n_launch != 3) begin failed++; $display("FAIL basic_launch got %0d want 3", o.n_launch); end
        tests_run++;
        if (o.n_emit != 3) begin failed++; $display("FAIL basic_emit got %0d want 3", o.n_emit); end
        tests_run++;
        if (o.n_done != 1) begin failed++; $display("FAIL basic_done got %0d want 1", o.n_done); end
        tests_run++;
        if (o.err != 0) begin failed++; $display("FAIL basic_err got %0d want 0", o.err); end
        tests_run++;
        if (o.lat != 5) begin failed++; $display("FAIL basic_latency got %0d want 5", o.lat); end
        tests_run++;
        if (o.bad != 0 || o.timeout != 0) begin
            failed++;
            $display("FAIL basic_protocol got bad=%0d timeout=%0d want 0/0", o.bad, o.timeout);
        end
        tests_run++;
        if (o.busy_after != 0) begin failed++; $display("FAIL basic_busy_after got %0d want 0", o.busy_after); end
    endtask

    task automatic test_single_window();
        row_obs_t o;
        run_row(4, 4, 1, 1, 0, -1, o);
        tests_run++;
        if (o.n_launch != 1 || o.n_emit != 1 || o.n_done != 1) begin
            failed++;
            $display("FAIL single_counts got launch=%0d emit=%0d done=%0d want 1/1/1",
                     o.n_launch, o.n_emit, o.n_done);
        end
        tests_run++;
        if (o.lat != 3) begin failed++; $display("FAIL single_latency got %0d want 3", o.lat); end
    endtask

    task automatic test_cfg_err();
        row_obs_t o;
        int cfgs [3][3] = '{'{3, 5, 1}, '{6, 0, 2}, '{6, 2, 0}};
        foreach (cfgs[i]) begin
            run_row(cfgs[i][0], cfgs[i][1], cfgs[i][2], 1, 0, -1, o);
            tests_run++;
            if (o.err != 1 || o.err_after != 1) begin
                failed++;
                $display("FAIL cfg_err_flag[%0d] got %0d/%0d want 1/1", i, o.err, o.err_after);
            end
            tests_run++;
            if (o.n_launch != 0 || o.n_done != 1 || o.busy_after != 0) begin
                failed++;
                $display("FAIL cfg_err_flow[%0d] got launch=%0d done=%0d busy=%0d want 0/1/0",
                         i, o.n_launch, o.n_done, o.busy_after);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (cfg_err !== 1'b0) begin failed++; $display("FAIL cfg_err_reset got %b want 0", cfg_err); end
    endtask

    task automatic test_stall();
        row_obs_t o;
        run_row(7, 3, 2, 1, 5, -1, o);
        tests_run++;
        if (o.emit_cycles != 18) begin
            failed++;
            $display("FAIL stall_valid_cycles got %0d want 18", o.emit_cycles);
        end
        tests_run++;
        if (o.bad != 0 || o.n_launch != 3 || o.n_done != 1) begin
            failed++;
            $display("FAIL stall_protocol got bad=%0d launch=%0d done=%0d want 0/3/1",
                     o.bad, o.n_launch, o.n_done);
        end
    endtask

    task automatic test_abort();
        row_obs_t o;
        run_row(7, 3, 2, 2, 0, 1, o);
        tests_run++;
        if (o.n_launch != 2 || o.n_emit != 1 || o.emit_cycles != 1) begin
            failed++;
            $display("FAIL abort_counts got launch=%0d emit=%0d valid=%0d want 2/1/1",
                     o.n_launch, o.n_emit, o.emit_cycles);
        end
        tests_run++;
        if (o.n_done != 1 || o.err != 0 || o.busy_after != 0) begin
            failed++;
            $display("FAIL abort_finish got done=%0d err=%0d busy=%0d want 1/0/0",
                     o.n_done, o.err, o.busy_after);
        end
    endtask

    task automatic test_reset_midrow();
        row_obs_t o;
        int seen;
        seen = 0;
        start = 1'b1;
        if_size = 3'd7;
        filter_size = 3'd3;
        stride = 3'd2;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (inner_start) seen = 1;
            @(negedge clk);
        end
        tests_run++;
        if (seen != 1) begin failed++; $display("FAIL midrow_launch got %0d want 1", seen); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({inner_start, psum_valid, busy, cfg_err, all_done, window_idx} !== 8'b0) begin
            failed++;
            $display("FAIL midrow_reset got %b want 00000000",
                     {inner_start, psum_valid, busy, cfg_err, all_done, window_idx});
        end
        run_row(7, 3, 2, 2, 0, -1, o);
        tests_run++;
        if (o.lat != 5 || o.n_launch != 3 || o.n_emit != 3 || o.n_done != 1 || o.bad != 0) begin
            failed++;
            $display("FAIL midrow_rerun got lat=%0d launch=%0d emit=%0d done=%0d bad=%0d want 5/3/3/1/0",
                     o.lat, o.n_launch, o.n_emit, o.n_done, o.bad);
        end
    endtask

    task automatic test_random();
        row_obs_t o;
        int ifs, fs, st, pd, stall, nw, en;
        for (int r = 0; r < 30; r++) begin
            ifs = int'($urandom_range(0, 7));
            fs = int'($urandom_range(0, 7));
            st = int'($urandom_range(0, 7));
            pd = int'($urandom_range(1, 4));
            stall = int'($urandom_range(0, 3));
            nw = model_nwin(ifs, fs, st);
            en = model_err(ifs, fs, st);
            run_row(ifs, fs, st, pd, stall, -1, o);
            tests_run++;
            if (o.err != en || o.n_launch != nw || o.n_emit != nw) begin
                failed++;
                $display("FAIL rand_row[%0d] if=%0d f=%0d s=%0d got err=%0d launch=%0d emit=%0d want %0d/%0d/%0d",
                         r, ifs, fs, st, o.err, o.n_launch, o.n_emit, en, nw, nw);
            end
            tests_run++;
            if (o.lat != model_lat(ifs, fs, st) || o.emit_cycles != nw * (stall + 1)) begin
                failed++;
                $display("FAIL rand_timing[%0d] got lat=%0d valid=%0d want %0d/%0d",
                         r, o.lat, o.emit_cycles, model_lat(ifs, fs, st), nw * (stall + 1));
            end
            tests_run++;
            if (o.n_done != 1 || o.bad != 0 || o.timeout != 0 || o.busy_after != 0) begin
                failed++;
                $display("FAIL rand_protocol[%0d] got done=%0d bad=%0d to=%0d busy=%0d want 1/0/0/0",
                         r, o.n_done, o.bad, o.timeout, o.busy_after);
            end
        end
    endtask

    task automatic test_saturate();
        row_obs_t o;
        run_row(7, 1, 1, 1, 0, -1, o);
        tests_run++;
        if (o.n_launch != CELLS || o.lat != 9) begin
            failed++;
            $display("FAIL saturate got launch=%0d lat=%0d want %0d/9", o.n_launch, o.lat, CELLS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_window();
        test_cfg_err();
        test_stall();
        test_abort();
        test_reset_midrow();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter STRIDE_SIZE, default 2, stride port msb index (stride width STRIDE_SIZE+1).
REQ-002 SHALL have parameter CELL_NUMS, default 8, maximum output windows per row.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  begin one row; sampled only in IDLE.
REQ-006 SHALL have port stride  in  STRIDE_SIZE+1  window step.
REQ-007 SHALL have port filter_size  in  3  filter length.
REQ-008 SHALL have port if_size  in  3  input-feature row length.
REQ-009 SHALL have port par_done  in  1  checker finished one partial sum.
REQ-010 SHALL have port chk_done  in  1  checker global Done; aborts the row.
REQ-011 SHALL have port psum_ready  in  1  downstream accepts the partial sum.
REQ-012 SHALL have port inner_start  out  1  one-cycle launch pulse to the checker.
REQ-013 SHALL have port psum_valid  out  1  partial sum available.
REQ-014 SHALL have port window_idx  out  3  current window index.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port cfg_err  out  1  illegal configuration flag, held until the next accepted start.
REQ-017 SHALL have port all_done  out  1  one-cycle row-complete pulse.

Function
REQ-018 SHALL implement states IDLE, CHECK, DIVIDE, LAUNCH, WAIT_PAR, EMIT, FINISH.
REQ-019 IDLE with start=1 SHALL latch stride, filter_size and if_size, clear cfg_err and window_idx, and go to CHECK; start outside IDLE SHALL be ignored.
REQ-020 CHECK SHALL go to FINISH with cfg_err=1 when stride==0, filter_size==0 or filter_size>if_size.
REQ-021 Otherwise CHECK SHALL load rem=if_size-filter_size (4-bit) and num_win=1 (4-bit), then go to DIVIDE.
REQ-022 DIVIDE SHALL perform one step per cycle: while rem>=stride, rem-=stride and num_win+=1; when rem<stride it SHALL go to LAUNCH.
REQ-023 The computed num_win SHALL equal floor((if_size-filter_size)/stride)+1 and SHALL be saturated to CELL_NUMS.
REQ-024 LAUNCH SHALL assert inner_start for exactly one cycle, then go to WAIT_PAR.
REQ-025 WAIT_PAR SHALL stay until par_done=1, then go to EMIT.
REQ-026 When par_done and chk_done are high in the same cycle, chk_done SHALL win and the FSM SHALL go to FINISH.
REQ-027 EMIT SHALL hold psum_valid=1 with window_idx stable until psum_ready=1.
REQ-028 On the EMIT handshake, if window_idx==num_win-1 the FSM SHALL go to FINISH; else window_idx SHALL increment and the FSM SHALL go to LAUNCH.
REQ-029 psum_ready while not in EMIT SHALL have no effect.
REQ-030 FINISH SHALL assert all_done for one cycle and return to IDLE; cfg_err and window_idx SHALL hold their values.
REQ-031 Minimum latency from start to first inner_start SHALL be 3 cycles plus one cycle per DIVIDE subtraction.

Reset
REQ-032 rst SHALL force IDLE and zero all outputs and internal registers on the next edge, overriding any in-flight state.
REQ-033 After rst, start SHALL be accepted on the first cycle rst is low.

Structure
REQ-034 The state encoding and the CELL_NUMS default SHALL live in the shared accelerator package.
REQ-035 The repeated-subtraction divider SHALL be one sub-module, window_count_div, with a start/done handshake.

Verification
REQ-036 if_size=7, filter_size=3, stride=2, psum_ready=1, par_done 2 cycles after each inner_start -> num_win=3, three inner_start pulses, window_idx 0,1,2, one all_done, cfg_err=0.
REQ-037 if_size=4, filter_size=4, stride=1 -> exactly one inner_start and one psum handshake, then all_done.
REQ-038 if_size=3, filter_size=5 -> cfg_err=1, all_done pulse, no inner_start, busy low after FINISH.
REQ-039 psum_ready held low for 5 cycles in EMIT -> psum_valid high for all 5 cycles, window_idx unchanged, no inner_start.
REQ-040 chk_done and par_done both high in WAIT_PAR on window 1 of 3 -> FINISH, no psum_valid, all_done pulse.
REQ-041 rst pulsed during WAIT_PAR -> next cycle state IDLE and all outputs 0; a following start runs a full row correctly.
